// File: rtl/ps2_scancode_sequencer_if.sv
// ps2_scancode_sequencer_if
//   Byte input strobe, event output handshake and status flags of the
//   PS/2 scan-code sequencer bundled as one interface.
//   master : producer/consumer side (drives byte_in/byte_valid/ev_ready)
//   slave  : sequencer side (drives event head, count and status flags)
//   FIFO_DEPTH must match the sequencer instance (sets ev_count width).
interface ps2_scancode_sequencer_if #(
  parameter int FIFO_DEPTH = 4
);
  logic [7:0]                    byte_in;
  logic                          byte_valid;
  logic [7:0]                    ev_code;
  logic                          ev_ext;
  logic                          ev_break;
  logic                          ev_valid;
  logic                          ev_ready;
  logic [$clog2(FIFO_DEPTH):0]   ev_count;
  logic                          seq_err;
  logic                          overflow;
  logic                          busy;

  modport master (
    output byte_in, byte_valid, ev_ready,
    input  ev_code, ev_ext, ev_break, ev_valid, ev_count,
           seq_err, overflow, busy
  );

  modport slave (
    input  byte_in, byte_valid, ev_ready,
    output ev_code, ev_ext, ev_break, ev_valid, ev_count,
           seq_err, overflow, busy
  );
endinterface

// File: rtl/ps2_scancode_sequencer.sv
// ps2_scancode_sequencer
//   Assembles decoded PS/2 set-2 scan-code bytes (with E0/F0 prefixes)
//   into key events {code, ext, break} and queues them in a show-ahead
//   FIFO. Flags misplaced prefixes, 00/FF error codes and inter-byte
//   timeouts with a one-cycle seq_err pulse; sticky overflow on drop.
//   Ports:
//     clk   : clock, posedge
//     rst_n : asynchronous active-low reset
//     bus   : ps2_scancode_sequencer_if.slave (byte in, event out, status)
module ps2_scancode_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  ps2_scancode_sequencer_if.slave       bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXT     = 2'd1;
  localparam logic [1:0] S_BRK     = 2'd2;
  localparam logic [1:0] S_EXT_BRK = 2'd3;

  localparam logic [7:0] B_EXT = 8'hE0;
  localparam logic [7:0] B_BRK = 8'hF0;

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [TW-1:0] r_tcnt;
  logic          w_emit;
  logic          w_err;
  logic          w_ext;
  logic          w_brk;
  logic          w_is_pfx;

  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_seq_err;
  logic          w_pop;
  logic          w_push;
  logic          w_full;
  logic          w_valid;
  logic [9:0]    w_head;

  // ---------------- sequencer FSM ----------------
  assign w_is_pfx = (bus.byte_in == B_EXT) || (bus.byte_in == B_BRK);

  always_comb begin
    w_next = r_state;
    w_emit = 1'b0;
    w_err  = 1'b0;
    w_ext  = 1'b0;
    w_brk  = 1'b0;
    if (bus.byte_valid) begin
      if (bus.byte_in == 8'h00 || bus.byte_in == 8'hFF) begin
        w_err  = 1'b1;
        w_next = S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.byte_in == B_EXT)      w_next = S_EXT;
            else if (bus.byte_in == B_BRK) w_next = S_BRK;
            else                           w_emit = 1'b1;
          end
          S_EXT: begin
            // a repeated E0 keeps the extended context without error
            if (bus.byte_in == B_BRK) w_next = S_EXT_BRK;
            else if (bus.byte_in != B_EXT) begin
              w_emit = 1'b1;
              w_ext  = 1'b1;
              w_next = S_IDLE;
            end
          end
          S_BRK: begin
            w_next = S_IDLE;
            if (w_is_pfx) w_err = 1'b1;
            else begin
              w_emit = 1'b1;
              w_brk  = 1'b1;
            end
          end
          default: begin
            w_next = S_IDLE;
            if (w_is_pfx) w_err = 1'b1;
            else begin
              w_emit = 1'b1;
              w_ext  = 1'b1;
              w_brk  = 1'b1;
            end
          end
        endcase
      end
    end else if (r_state != S_IDLE && r_tcnt == TO_LAST) begin
      // inter-byte timeout abandons the partial sequence
      w_err  = 1'b1;
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_tcnt    <= '0;
      r_seq_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_seq_err <= w_err;
      if (bus.byte_valid || r_state == S_IDLE || w_err) r_tcnt <= '0;
      else                                              r_tcnt <= r_tcnt + TW'(1);
    end
  end

  // ---------------- event FIFO ----------------
  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_pop   = w_valid && bus.ev_ready;
  // when full, a simultaneous pop frees the slot the new event needs
  assign w_push  = w_emit && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {w_ext, w_brk, bus.byte_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_emit && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  // head fields forced to zero while empty so reset shows a clean bus
  assign w_head       = r_mem[r_rd];
  assign bus.ev_valid = w_valid;
  assign bus.ev_code  = w_valid ? w_head[7:0] : '0;
  assign bus.ev_break = w_valid & w_head[8];
  assign bus.ev_ext   = w_valid & w_head[9];
  assign bus.ev_count = r_count;
  assign bus.seq_err  = r_seq_err;
  assign bus.overflow = r_ovf;
  assign bus.busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// tb_ps2_scancode_sequencer
//   Directed scenarios followed by randomized byte streams, each cycle
//   compared against a prefix-flag parser and event queue model.
module tb_ps2_scancode_sequencer;
  localparam int DEPTH = 4;
  localparam int TO    = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_scancode_sequencer_if #(.FIFO_DEPTH(DEPTH)) bus ();

  ps2_scancode_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ev_t;

  ev_t q[$];
  bit  pend_e0, pend_f0;
  int  quiet;
  bit  m_ovf, m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pend_e0 = 0; pend_f0 = 0; quiet = 0; m_ovf = 0; m_err = 0;
  endtask

  // One clock edge of the reference: prefixes accumulate as flags, a code
  // byte completes the event, misplaced prefixes/00/FF/quiet time abort.
  task automatic model_edge(input bit v, input logic [7:0] b, input bit rdy);
    bit  pop, emit, was_full;
    ev_t e;
    pop   = (q.size() > 0) && rdy;
    emit  = 0;
    m_err = 0;
    e     = '0;
    if (v) begin
      quiet = 0;
      if (b == 8'h00 || b == 8'hFF) begin
        m_err = 1; pend_e0 = 0; pend_f0 = 0;
      end else if (b == 8'hE0 || b == 8'hF0) begin
        if (pend_f0) begin
          m_err = 1; pend_e0 = 0; pend_f0 = 0;
        end else if (b == 8'hE0) pend_e0 = 1;
        else pend_f0 = 1;
      end else begin
        e = '{code: b, ext: pend_e0, brk: pend_f0};
        emit = 1; pend_e0 = 0; pend_f0 = 0;
      end
    end else if (pend_e0 || pend_f0) begin
      quiet++;
      if (quiet == TO) begin
        m_err = 1; pend_e0 = 0; pend_f0 = 0; quiet = 0;
      end
    end
    was_full = (q.size() == DEPTH);
    if (pop) void'(q.pop_front());
    if (emit) begin
      if (!was_full || pop) q.push_back(e);
      else m_ovf = 1;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 32'(bus.ev_valid), 32'(q.size() > 0));
    chk({tag, ".count"}, 32'(bus.ev_count), 32'(q.size()));
    chk({tag, ".busy"},  32'(bus.busy),     32'(pend_e0 || pend_f0));
    chk({tag, ".err"},   32'(bus.seq_err),  32'(m_err));
    chk({tag, ".ovf"},   32'(bus.overflow), 32'(m_ovf));
    if (q.size() > 0) begin
      chk({tag, ".code"}, 32'(bus.ev_code),  32'(q[0].code));
      chk({tag, ".ext"},  32'(bus.ev_ext),   32'(q[0].ext));
      chk({tag, ".brk"},  32'(bus.ev_break), 32'(q[0].brk));
    end
  endtask

  task automatic step(input string tag, input bit v, input logic [7:0] b, input bit rdy);
    bus.byte_valid = v;
    bus.byte_in    = b;
    bus.ev_ready   = rdy;
    @(posedge clk);
    #1;
    model_edge(v, b, rdy);
    check_outputs(tag);
  endtask

  task automatic quiet_cycles(input string tag, input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 8'($urandom), rdy);
  endtask

  task automatic do_reset();
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    bus.ev_ready   = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst.valid", 32'(bus.ev_valid), 32'd0);
    chk("rst.count", 32'(bus.ev_count), 32'd0);
    chk("rst.err",   32'(bus.seq_err),  32'd0);
    chk("rst.ovf",   32'(bus.overflow), 32'd0);
    chk("rst.busy",  32'(bus.busy),     32'd0);
    chk("rst.code",  32'(bus.ev_code),  32'd0);
    chk("rst.ext",   32'(bus.ev_ext),   32'd0);
    chk("rst.brk",   32'(bus.ev_break), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    bus.ev_ready   = 1'b0;
    do_reset();

    // make then break of the same key
    step("mk", 1, 8'h1C, 0);
    chk("mk.code", 32'(bus.ev_code), 32'h1C);
    step("brk.f0", 1, 8'hF0, 0);
    chk("brk.busy", 32'(bus.busy), 32'd1);
    step("brk.1c", 1, 8'h1C, 0);
    chk("brk.count", 32'(bus.ev_count), 32'd2);
    chk("brk.busy0", 32'(bus.busy), 32'd0);
    step("pop1", 0, 8'h00, 1);
    chk("pop1.brk", 32'(bus.ev_break), 32'd1);
    step("pop2", 0, 8'h00, 1);

    // extended release
    step("xb.e0", 1, 8'hE0, 0);
    step("xb.f0", 1, 8'hF0, 0);
    step("xb.75", 1, 8'h75, 0);
    chk("xb.head", 32'({bus.ev_code, bus.ev_ext, bus.ev_break}), 32'({8'h75, 2'b11}));
    step("xb.pop", 0, 8'h00, 1);
    chk("xb.empty", 32'(bus.ev_valid), 32'd0);

    // overflow: six makes into a 4-deep FIFO
    for (int i = 0; i < 6; i++) step("ovf.fill", 1, 8'(8'h15 + i), 0);
    chk("ovf.count", 32'(bus.ev_count), 32'd4);
    chk("ovf.flag",  32'(bus.overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("ovf.order", 32'(bus.ev_code), 32'(8'h15 + i));
      step("ovf.pop", 0, 8'h00, 1);
    end

    // protocol errors
    step("e.f0", 1, 8'hF0, 0);
    step("e.e0", 1, 8'hE0, 0);
    chk("e.pulse", 32'(bus.seq_err), 32'd1);
    step("e.ff", 1, 8'hFF, 0);
    chk("e.ff", 32'(bus.seq_err), 32'd1);
    step("e.1c", 1, 8'h1C, 0);
    chk("e.1c", 32'(bus.ev_code), 32'h1C);
    step("e.pop", 0, 8'h00, 1);

    // timeout
    step("to.e0", 1, 8'hE0, 0);
    quiet_cycles("to.wait", TO - 1, 0);
    chk("to.pre", 32'(bus.seq_err), 32'd0);
    step("to.fire", 0, 8'h00, 0);
    chk("to.err",  32'(bus.seq_err), 32'd1);
    chk("to.busy", 32'(bus.busy),    32'd0);
    step("to.2a", 1, 8'h2A, 0);
    chk("to.2a", 32'({bus.ev_code, bus.ev_ext, bus.ev_break}), 32'({8'h2A, 2'b00}));
    step("to.pop", 0, 8'h00, 1);

    // full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 4; i++) step("pp.fill", 1, 8'(8'h15 + i), 0);
    step("pp.both", 1, 8'h19, 1);
    chk("pp.count", 32'(bus.ev_count), 32'd4);
    chk("pp.ovf",   32'(bus.overflow), 32'd0);
    for (int i = 0; i < 4; i++) step("pp.drain", 0, 8'h00, 1);

    // reset mid-sequence and with stored events
    step("rs.evt", 1, 8'h33, 0);
    step("rs.e0", 1, 8'hE0, 0);
    do_reset();
    step("rs.1c", 1, 8'h1C, 0);
    chk("rs.1c", 32'({bus.ev_code, bus.ev_ext, bus.ev_break}), 32'({8'h1C, 2'b00}));
    chk("rs.cnt", 32'(bus.ev_count), 32'd1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 15)      b = 8'hE0;
      else if (r < 30) b = 8'hF0;
      else if (r < 33) b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      else             b = 8'($urandom_range(8'h01, 8'hDF));
      if (n % 1000 == 999) do_reset();
      else if ($urandom_range(0, 199) == 0) quiet_cycles("rnd.gap", TO + 2, 1'($urandom_range(0, 1)));
      else step("rnd", 1'($urandom_range(0, 99) < 55), b, 1'($urandom_range(0, 99) < 35));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
